dbuf2ddr: RTL and testbench

Write-back streamer that drains result data from the per-PE data buffers to DDR. It walks the enabled PEs in ascending index order and reads each PE buffer from address 0 to `conf_len`. Each read word becomes one DDR beat on a valid/ready stream, and a credit-limited output FIFO absorbs DDR back-pressure. It is the read-side counterpart of the DDR-to-dbuf loader and sits between the PE array buffers and the DDR write channel.

---
 rtl/dbuf2ddr.sv | 196 +++++++++++++++++++
 tb/tb_dbuf2ddr.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbuf2ddr.sv
// Write-back streamer: drains enabled PE data buffers (ascending PE, address 0..conf_len) into a DDR valid/ready stream.
// Optional build macro DBUF2DDR_RELU_EN zeroes negative DATA_W lanes at the FIFO write when the job's conf_relu is set.
module dbuf2ddr #(
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_W     = $clog2(BUF_DEPTH),
  parameter int PE_NUM     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16,
  parameter int BATCH      = 4,
  parameter int DDR_W      = DATA_W * BATCH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          done,
  input  logic [ADDR_W-1:0]             conf_len,
  input  logic [PE_NUM-1:0]             conf_mask,
  input  logic                          conf_relu,
  output logic [ADDR_W-1:0]             buf_rd_addr,
  output logic [PE_NUM-1:0]             buf_rd_en,
  input  logic [PE_NUM-1:0][DDR_W-1:0]  buf_rd_data,
  output logic [DDR_W-1:0]              ddr_data,
  output logic                          ddr_valid,
  input  logic                          ddr_ready,
  output logic                          ddr_last,
  output logic [1:0]                    dbg_state
);

  localparam int PE_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_DRAIN = 2'd2} state_t;

  // Stream handshake: a beat transfers on a rising clk edge with ddr_valid=1 and ddr_ready=1;
  // once ddr_valid is raised, ddr_valid/ddr_data/ddr_last hold until that transfer happens.

  state_t              state;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   addr;
  logic [PE_NUM-1:0]   rem_mask;
  logic                relu_q;

  logic                tag_vld  [RD_LAT];
  logic [PE_W-1:0]     tag_pe   [RD_LAT];
  logic                tag_last [RD_LAT];

  logic [DDR_W-1:0]    fifo_data [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_count;

  logic [PE_W-1:0]     cur_pe;
  logic [PE_NUM-1:0]   cur_onehot, rem_clr;
  logic [CW-1:0]       inflight, credit_used;
  logic                push_pending, pop, issue, last_word, job_last, any_tag;
  logic [DDR_W-1:0]    push_data;

  // Lowest set bit of the remaining mask selects the PE being read.
  always_comb begin
    cur_pe     = '0;
    cur_onehot = '0;
    for (int i = PE_NUM - 1; i >= 0; i--) begin
      if (rem_mask[i]) cur_pe = PE_W'(i);
    end
    if (rem_mask != '0) cur_onehot[cur_pe] = 1'b1;
    rem_clr = rem_mask & ~cur_onehot;
  end

  // Credits cover every word that is already, or will soon be, inside the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      inflight = inflight + CW'(tag_vld[i]);
    end
    any_tag = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      any_tag = any_tag | tag_vld[i];
    end
  end

  assign push_pending = tag_vld[RD_LAT-1];
  assign credit_used  = inflight + fifo_count + CW'(push_pending);
  assign issue        = (state == S_READ) && (credit_used < CW'(FIFO_DEPTH));
  assign last_word    = (addr == len_q);
  assign job_last     = last_word && (rem_clr == '0);
  assign pop          = ddr_valid && ddr_ready;

  assign buf_rd_en   = issue ? cur_onehot : '0;
  assign buf_rd_addr = issue ? addr : '0;
  assign done        = (state == S_IDLE);
  assign dbg_state   = state;

  always_comb begin
    push_data = buf_rd_data[tag_pe[RD_LAT-1]];
`ifdef DBUF2DDR_RELU_EN
    if (relu_q) begin
      for (int l = 0; l < BATCH; l++) begin
        if (push_data[l*DATA_W + DATA_W - 1]) push_data[l*DATA_W +: DATA_W] = '0;
      end
    end
`endif
  end

`ifndef DBUF2DDR_RELU_EN
  logic unused_relu;
  assign unused_relu = relu_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len_q    <= '0;
      addr     <= '0;
      rem_mask <= '0;
      relu_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= conf_len;
            rem_mask <= conf_mask;
            relu_q   <= conf_relu;
            addr     <= '0;
            state    <= (conf_mask != '0) ? S_READ : S_DRAIN;
          end
        end
        S_READ: begin
          if (issue) begin
            addr <= last_word ? '0 : addr + ADDR_W'(1);
            if (last_word) rem_mask <= rem_clr;
            if (job_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leave as soon as the final beat is handshaking so done rises right after it.
          if (!any_tag && ((fifo_count == '0) || (fifo_count == CW'(1) && pop)))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_pe[i]   <= '0;
        tag_last[i] <= 1'b0;
      end
    end else begin
      tag_vld[0]  <= issue;
      tag_pe[0]   <= cur_pe;
      tag_last[0] <= job_last;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_pe[i]   <= tag_pe[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_pending) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_last[wr_ptr] <= tag_last[RD_LAT-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CW'(push_pending) - CW'(pop);
    end
  end

  assign ddr_valid = (fifo_count != '0);
  assign ddr_data  = fifo_data[rd_ptr];
  assign ddr_last  = ddr_valid & fifo_last[rd_ptr];

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push_pending |-> (fifo_count < CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_dbuf2ddr.sv
// Randomized bench for dbuf2ddr: buffer model with 2-cycle read latency, expected-beat queue built from the
// PE-major/address-major drain rule, stream-protocol and timing checks.
module tb_dbuf2ddr;

  localparam int DATA_W = 16, BATCH = 4, DDR_W = 64;
  localparam int PE_NUM = 32, BUF_DEPTH = 256, ADDR_W = 8;
`ifdef DBUF2DDR_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                          start, done, conf_relu, ddr_valid, ddr_ready, ddr_last;
  logic [ADDR_W-1:0]             conf_len, buf_rd_addr;
  logic [PE_NUM-1:0]             conf_mask, buf_rd_en;
  logic [PE_NUM-1:0][DDR_W-1:0]  buf_rd_data, rd_s1;
  logic [DDR_W-1:0]              ddr_data;
  logic [1:0]                    dbg_state;

  dbuf2ddr dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .conf_len(conf_len), .conf_mask(conf_mask), .conf_relu(conf_relu),
    .buf_rd_addr(buf_rd_addr), .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data),
    .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready), .ddr_last(ddr_last),
    .dbg_state(dbg_state)
  );

  // ---------------- PE buffer model (read latency 2) ----------------
  logic [DDR_W-1:0] bufmem [PE_NUM][BUF_DEPTH];
  always @(posedge clk) begin
    for (int p = 0; p < PE_NUM; p++) begin
      if (buf_rd_en[p]) rd_s1[p] <= bufmem[p][buf_rd_addr];
    end
    buf_rd_data <= rd_s1;
  end

  // ---------------- ready driver ----------------
  int ready_mode = 0;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    phase = phase + 1;
    case (ready_mode)
      0:       ddr_ready = 1'b1;
      1:       ddr_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: ddr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_err = 0;
  logic [DDR_W:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DDR_W-1:0] relu_model(input logic [DDR_W-1:0] w, input bit en);
    relu_model = w;
    for (int l = 0; l < BATCH; l++) begin
      if (RELU_ON && en && w[l*DATA_W + DATA_W - 1]) relu_model[l*DATA_W +: DATA_W] = '0;
    end
  endfunction

  int n_beats, n_en, first_valid, first_en, last_hs, done_rise, start_cyc, exp_beats;
  bit stall_prev = 0, done_prev = 1, prev_last;
  logic [DDR_W-1:0] prev_data;

  always @(negedge clk) begin
    logic [DDR_W:0] e;
    if (!rst_n) begin
      stall_prev = 0;
      done_prev  = 1;
    end else begin
      if (buf_rd_en != '0) begin
        n_en++;
        if (first_en < 0) first_en = cyc;
        chk("rd_en_onehot", $onehot(buf_rd_en), 1);
      end
      if (stall_prev) chk("stall_hold", {ddr_valid, ddr_last, ddr_data}, {1'b1, prev_last, prev_data});
      if (ddr_valid && first_valid < 0) first_valid = cyc;
      if (ddr_valid && ddr_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", ddr_data, e[DDR_W-1:0]);
          chk("beat_last", ddr_last, e[DDR_W]);
        end
        n_beats++;
        last_hs = cyc;
      end
      if (done && !done_prev) done_rise = cyc;
      done_prev  = done;
      stall_prev = ddr_valid && !ddr_ready;
      prev_data  = ddr_data;
      prev_last  = ddr_last;
    end
  end

  // ---------------- driver tasks ----------------
  // fill: 0 random words, 1 word = address, 2 fixed ReLU lane pattern
  task automatic start_job(input logic [31:0] mask, input int len, input bit relu,
                           input int rmode, input int fill);
    int idx;
    exp_q.delete();
    exp_beats = 0;
    for (int p = 0; p < PE_NUM; p++)
      if (mask[p]) exp_beats += len + 1;
    idx = 0;
    for (int p = 0; p < PE_NUM; p++) begin
      if (mask[p]) begin
        for (int a = 0; a <= len; a++) begin
          case (fill)
            0:       bufmem[p][a] = {$urandom, $urandom};
            1:       bufmem[p][a] = DDR_W'(a);
            default: bufmem[p][a] = {16'h8001, 16'h7FFF, 16'h8001, 16'h7FFF};
          endcase
          idx++;
          exp_q.push_back({idx == exp_beats, relu_model(bufmem[p][a], relu)});
        end
      end
    end
    n_beats = 0; n_en = 0; first_valid = -1; first_en = -1; last_hs = -1; done_rise = -1;
    ready_mode = rmode;
    conf_mask = mask; conf_len = ADDR_W'(len); conf_relu = relu;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_job(input bit poke);
    bit ok = 0;
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; conf_mask = $urandom; conf_len = ADDR_W'($urandom); conf_relu = ~conf_relu;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk); #1;
      if (done) ok = 1;
    end
    chk("job_timeout", ok, 1);
    @(posedge clk); #1;
    chk("beat_count", n_beats, exp_beats);
    chk("rd_count", n_en, exp_beats);
    chk("exp_left", exp_q.size(), 0);
    if (exp_beats > 0) chk("done_after_last", done_rise - last_hs, 1);
    if (exp_beats > 0 && ready_mode == 0) chk("no_bubble", last_hs - first_valid + 1, exp_beats);
  endtask

  task automatic run_job(input logic [31:0] mask, input int len, input bit relu,
                         input int rmode, input int fill, input bit poke);
    start_job(mask, len, relu, rmode, fill);
    finish_job(poke && mask != 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    logic [31:0] m;
    rst_n = 1'b0; start = 1'b0; conf_mask = '0; conf_len = '0; conf_relu = 1'b0; ddr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 1);
    chk("rst_valid", ddr_valid, 0);
    chk("rst_last", ddr_last, 0);
    chk("rst_data", ddr_data, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_rd_addr", buf_rd_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single PE, address-valued words, latency figures
    run_job(32'h0000_0001, 3, 0, 0, 1, 0);
    chk("first_rd_en_lat", first_en - start_cyc, 1);
    chk("first_valid_lat", first_valid - start_cyc, 4);

    // sparse mask across PE boundaries, including a busy start
    run_job(32'h8000_0011, 1, 0, 0, 0, 1);

    // 1,0,0,1 ready pattern
    run_job(32'h1 << $urandom_range(0, 31), 7, 0, 1, 0, 0);

    // empty mask
    conf_mask = '0; conf_len = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.delete(); n_beats = 0;
    chk("mask0_busy", done, 0);
    @(posedge clk); #1;
    chk("mask0_idle", done, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("mask0_beats", n_beats, 0);

    // reset in the middle of an 8-beat job
    start_job(32'h0000_0004, 7, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (n_beats >= 3) ok = 1;
    end
    chk("midreset_wait", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", done, 1);
    chk("midrst_valid", ddr_valid, 0);
    chk("midrst_last", ddr_last, 0);
    chk("midrst_data", ddr_data, 0);
    chk("midrst_rd_en", buf_rd_en, 0);
    chk("midrst_rd_addr", buf_rd_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", done, 1);
    run_job(32'h0000_0200, 1, 0, 0, 0, 0);

    // ReLU lane pattern, both settings
    run_job(32'h0000_0008, 1, 1, 0, 2, 0);
    run_job(32'h0000_0008, 0, 0, 0, 2, 0);

    // full-depth buffer
    run_job(32'h1 << $urandom_range(0, 31), BUF_DEPTH - 1, 0, 2, 0, 0);

    // random jobs
    for (int j = 0; j < 8; j++) begin
      case ($urandom_range(0, 2))
        0:       m = 32'h1 << $urandom_range(0, 31);
        1:       m = $urandom & $urandom & $urandom;
        default: m = $urandom;
      endcase
      if (m == 0) m = 32'h1;
      run_job(m, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
